// File: rtl/intlv_pkg.sv
// Shared constants, FSM state type and closed-form reference permutation for the
// WiMAX QPSK block interleaver write path.
package intlv_pkg;

  localparam int unsigned NCBPS_QPSK = 192;
  localparam int unsigned D_ROWS     = 16;
  localparam int unsigned COLS       = NCBPS_QPSK / D_ROWS;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } wr_state_t;

  // mk = (NCBPS/D)*(k mod D) + floor(k/D)
  function automatic int unsigned perm_addr(input int unsigned k);
    return COLS * (k % D_ROWS) + k / D_ROWS;
  endfunction

endpackage

// File: rtl/intlv_perm_ctr.sv
// Incremental row/col/address tracker for the first interleaver permutation.
// addr always holds mk for the bit index currently being tracked.
module intlv_perm_ctr
  import intlv_pkg::*;
#(
  parameter int unsigned NCBPS = NCBPS_QPSK,
  parameter int unsigned D     = D_ROWS,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [AW-1:0] addr
);

  localparam int unsigned RW   = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned STEP = NCBPS / D;

  logic [RW-1:0] row;
  logic [AW-1:0] col;

  // Wrapping a row restarts one column to the right, i.e. addr = col + 1.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (en) begin
      if (row == RW'(D - 1)) begin
        row  <= '0;
        col  <= col + AW'(1);
        addr <= col + AW'(1);
      end else begin
        row  <= row + RW'(1);
        addr <= addr + AW'(STEP);
      end
    end
  end

endmodule

// File: rtl/intlv_wr_addr_gen.sv
// Write-side address generator for the WiMAX block interleaver (one buffer write per bit).
// Optional macro INTLV_BYPASS_EN adds a 'bypass' input selecting identity write order.
module intlv_wr_addr_gen
  import intlv_pkg::*;
#(
  parameter int unsigned NCBPS = NCBPS_QPSK,
  parameter int unsigned D     = D_ROWS,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
`ifdef INTLV_BYPASS_EN
  input  logic          bypass,
`endif
  input  logic          in_valid,
  input  logic          in_data,
  output logic          in_ready,
  input  logic          buf_ready,
  output logic [AW-1:0] wraddress,
  output logic          wrdata,
  output logic          valid_out,
  output logic          block_done
);

  wr_state_t     state, state_next;
  logic [AW-1:0] k;
  logic [AW-1:0] perm;
  logic [AW-1:0] addr_sel;
  logic          accept;
  logic          last;
  logic          ctr_en;
  logic          ctr_clr;

  assign in_ready = buf_ready;
  assign accept   = in_valid & buf_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = FILL;
      FILL:    if (accept && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    last    = (state == FILL) && (k == AW'(NCBPS - 1));
    ctr_en  = accept;
    ctr_clr = accept && last;
  end

  always_ff @(posedge clk) begin
    if (reset)        k <= '0;
    else if (ctr_clr) k <= '0;
    else if (ctr_en)  k <= k + AW'(1);
  end

  intlv_perm_ctr #(
    .NCBPS (NCBPS),
    .D     (D),
    .AW    (AW)
  ) u_perm_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (ctr_en),
    .clr   (ctr_clr),
    .addr  (perm)
  );

`ifdef INTLV_BYPASS_EN
  logic bypass_q;
  logic use_bypass;

  // Live value applies to the first bit of a block; the latched copy covers the rest.
  always_ff @(posedge clk) begin
    if (reset)              bypass_q <= 1'b0;
    else if (state == IDLE) bypass_q <= bypass;
  end

  assign use_bypass = (state == IDLE) ? bypass : bypass_q;
  assign addr_sel   = use_bypass ? k : perm;
`else
  assign addr_sel = perm;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out  <= 1'b0;
      block_done <= 1'b0;
      wraddress  <= '0;
      wrdata     <= 1'b0;
    end else begin
      valid_out  <= accept;
      block_done <= accept && last;
      if (accept) begin
        wraddress <= addr_sel;
        wrdata    <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_intlv_wr_addr_gen.sv
// Self-checking bench for intlv_wr_addr_gen: arithmetic reference model plus directed checks.
module tb_intlv_wr_addr_gen;

  localparam int unsigned NB   = 192;
  localparam int unsigned ROWS = 16;
  localparam int unsigned STEP = NB / ROWS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bypass = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic       in_ready;
  logic       buf_ready = 1'b0;
  logic [7:0] wraddress;
  logic       wrdata;
  logic       valid_out;
  logic       block_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  intlv_wr_addr_gen #(
    .NCBPS (NB),
    .D     (ROWS),
    .AW    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef INTLV_BYPASS_EN
    .bypass     (bypass),
`endif
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .buf_ready  (buf_ready),
    .wraddress  (wraddress),
    .wrdata     (wrdata),
    .valid_out  (valid_out),
    .block_done (block_done)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: bit index within block, expected outputs for the next cycle.
  int unsigned mk = 0;
  bit          byp_lat = 0;
  bit          model_live = 0;
  int unsigned exp_addr = 0;
  bit          exp_valid = 0, exp_data = 0, exp_done = 0;

  always @(posedge clk) begin
    if (reset) begin
      mk = 0; exp_valid = 0; exp_addr = 0; exp_data = 0; exp_done = 0;
      model_live = 1;
    end else begin
      exp_done = 0;
      if (mk == 0) byp_lat = bypass;
      if (in_valid && buf_ready) begin
        exp_valid = 1;
        exp_addr  = byp_lat ? mk : STEP * (mk % ROWS) + mk / ROWS;
        exp_data  = in_data;
        exp_done  = (mk == NB - 1);
        mk        = (mk + 1) % NB;
      end else begin
        exp_valid = 0;
      end
    end
  end

  // Write log and buffer image captured from the DUT outputs.
  int unsigned wq[$];
  int unsigned done_idx[$];
  bit          mem [256];

  always @(negedge clk) begin
    if (model_live) begin
      chk("valid_out",  valid_out,  exp_valid);
      chk("block_done", block_done, exp_done);
      chk("wraddress",  wraddress,  exp_addr);
      chk("wrdata",     wrdata,     exp_data);
      chk("in_ready",   in_ready,   buf_ready);
      if (valid_out) begin
        wq.push_back(wraddress);
        mem[wraddress] = wrdata;
        if (block_done) done_idx.push_back(wq.size() - 1);
      end
    end
  end

  task automatic drive(input bit v, input bit d, input bit br);
    in_valid = v; in_data = d; buf_ready = br;
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wq.delete();
    done_idx.delete();
  endtask

  task automatic settle();
    drive(0, 0, 1);
    drive(0, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_valid", valid_out, 0);
    chk("rst_done",  block_done, 0);
    chk("rst_addr",  wraddress, 0);

    // One full block, data = k[0]
    clear_log();
    for (int unsigned k = 0; k < NB; k++) drive(1, k[0], 1);
    settle();
    chk("t1_nwrites", wq.size(), NB);
    chk("t1_w0",   wq[0],   0);
    chk("t1_w1",   wq[1],   12);
    chk("t1_w15",  wq[15],  180);
    chk("t1_w16",  wq[16],  1);
    chk("t1_w17",  wq[17],  13);
    chk("t1_w191", wq[191], 191);
    chk("t1_ndone", done_idx.size(), 1);
    if (done_idx.size() > 0) chk("t1_done_at", done_idx[0], NB - 1);

    // Sequential readback: buffer address a holds bit k = (a mod 12)*16 + a/12
    for (int unsigned a = 0; a < NB; a++) begin
      int unsigned kk;
      kk = (a % STEP) * ROWS + a / STEP;
      chk("t2_readback", mem[a], kk % 2);
    end

    // Stalls: buf_ready low at k=37, in_valid low at k=100
    clear_log();
    for (int unsigned k = 0; k < NB; k++) begin
      if (k == 37)  repeat (5) drive(1, 1, 0);
      if (k == 100) repeat (3) drive(0, 0, 1);
      drive(1, k[0], 1);
    end
    settle();
    chk("t3_nwrites", wq.size(), NB);
    chk("t3_w37",  wq[37],  62);
    chk("t3_w100", wq[100], 54);
    chk("t3_ndone", done_idx.size(), 1);

    // Back-to-back blocks
    clear_log();
    for (int unsigned k = 0; k < 2 * NB; k++) drive(1, k[1], 1);
    settle();
    chk("t4_w191", wq[191], 191);
    chk("t4_w192", wq[192], 0);
    chk("t4_w193", wq[193], 12);
    chk("t4_ndone", done_idx.size(), 2);
    if (done_idx.size() == 2) chk("t4_done2_at", done_idx[1], 2 * NB - 1);

    // Reset mid-block at k=77
    for (int unsigned k = 0; k < 77; k++) drive(1, k[0], 1);
    reset = 1;
    drive(1, 1, 1);
    reset = 0;
    chk("t5_valid_after_rst", valid_out, 0);
    clear_log();
    for (int unsigned k = 0; k < NB; k++) drive(1, k[0], 1);
    settle();
    chk("t5_w0", wq[0], 0);
    chk("t5_w1", wq[1], 12);
    chk("t5_ndone", done_idx.size(), 1);
    if (done_idx.size() > 0) chk("t5_done_at", done_idx[0], NB - 1);

`ifdef INTLV_BYPASS_EN
    // Identity order; a mid-block toggle only affects the following block
    clear_log();
    bypass = 1;
    for (int unsigned k = 0; k < NB; k++) begin
      if (k == 50) bypass = 0;
      drive(1, k[0], 1);
    end
    for (int unsigned k = 0; k < 4; k++) drive(1, k[0], 1);
    settle();
    chk("t6_w1",   wq[1],   1);
    chk("t6_w100", wq[100], 100);
    chk("t6_w191", wq[191], 191);
    chk("t6_nb1",  wq[193], 12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
